move_sequencer: RTL

- Consumer end of the one-cycle player-move pulse interface (rotate/down/left/right).
- Merges user pulses with an internal gravity timer and queues the resulting move commands in a small FIFO.
- Presents one command at a time to the game-board engine over a valid/ready handshake.
- Sits between the key-pulse front end and the piece/collision logic.

---
 rtl/move_pkg.sv | 25 ++
 rtl/move_fifo.sv | 85 ++++++++
 rtl/move_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/move_pkg.sv
// -----------------------------------------------------------------------------
// move_pkg
// Shared types for the move sequencer: the move opcode enumeration and the
// command word carried through the command FIFO.
// -----------------------------------------------------------------------------
package move_pkg;

    // Opcode encoding is visible on the engine interface, so values are fixed.
    typedef enum logic [1:0] {
        ROT   = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        DOWN  = 2'd3
    } move_op_t;

    // One queued command: the move and whether gravity (not the player) made it.
    typedef struct packed {
        move_op_t op;
        logic     auto;
    } move_cmd_t;

    // Neutral command used as a default and for the empty-queue output value.
    localparam move_cmd_t CMD_NONE = '{op: ROT, auto: 1'b0};

endpackage : move_pkg

// File: rtl/move_fifo.sv
// -----------------------------------------------------------------------------
// move_fifo
// Small synchronous FIFO of move commands. The head entry is read
// combinationally from storage (no fall-through: a push is visible only after
// the clock edge that writes it). A push while full is accepted only when a
// pop happens in the same cycle, in which case the occupancy is unchanged.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high; empties the queue
//   i_push   write i_data this cycle (ignored if full and not popping)
//   i_data   command to write
//   i_pop    remove the head entry this cycle (ignored if empty)
//   o_head   current head entry (meaningless while o_empty)
//   o_full   occupancy == DEPTH
//   o_empty  occupancy == 0
//   o_level  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module move_fifo
    import move_pkg::*;
#(
    parameter int DEPTH = 4     // power of two, at least 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  move_cmd_t              i_data,
    input  logic                   i_pop,
    output move_cmd_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int AW = $clog2(DEPTH);

    move_cmd_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;

    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_level == (AW + 1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
    // the natural overflow of the increment the modulo-DEPTH wrap.
    // NOTE: clocked state uses non-blocking (<=) assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; an entry is
    // only ever read after it has been written, and r_level guards that.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule : move_fifo

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
// Consumer of the one-cycle player move pulses. Merges the pulses with an
// internal gravity timer, queues at most one command per cycle in move_fifo,
// and presents the queue head to the game-board engine over valid/ready.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high; clears queue, timer, overflow
//   rotate     one-cycle rotate request pulse
//   down       one-cycle manual soft-drop pulse
//   left       one-cycle move-left pulse
//   right      one-cycle move-right pulse
//   pause      level; freezes gravity, ignores user pulses, gates cmd_valid
//   cmd_valid  head command available
//   cmd_ready  engine accepts the head command this cycle
//   cmd_op     head opcode (ROT=0, LEFT=1, RIGHT=2, DOWN=3)
//   cmd_auto   head command was generated by gravity
//   overflow   sticky; some user command was dropped
//   level      current queue occupancy
// -----------------------------------------------------------------------------
module move_sequencer
    import move_pkg::*;
#(
    parameter int DEPTH          = 4,           // power of two, at least 2
    parameter int GRAVITY_CYCLES = 50_000_000   // at least 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rotate,
    input  logic                   down,
    input  logic                   left,
    input  logic                   right,
    input  logic                   pause,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [1:0]             cmd_op,
    output logic                   cmd_auto,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int            CW        = $clog2(GRAVITY_CYCLES);
    localparam logic [CW-1:0] GRAV_LAST = CW'(GRAVITY_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] r_grav_cnt;
    logic          r_grav_pending;
    logic          r_overflow;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic          w_rot;
    logic          w_left;
    logic          w_right;
    logic          w_down;
    logic          w_multi;
    logic          w_req;
    logic          w_user_req;
    move_cmd_t     w_sel_cmd;
    logic          w_space;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_tick;
    logic          w_grav_push;
    logic          w_manual_down_push;
    logic [CW-1:0] w_cnt_next;
    logic          w_pending_next;

    move_cmd_t              w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_level;

    // User pulses do not exist while paused; they are not even overflow.
    assign w_rot   = rotate & ~pause;
    assign w_left  = left   & ~pause;
    assign w_right = right  & ~pause;
    assign w_down  = down   & ~pause;

    // More than one user pulse in a cycle means all but the winner are lost.
    assign w_multi = (w_rot   & (w_left | w_right | w_down)) |
                     (w_left  & (w_right | w_down))          |
                     (w_right &  w_down);

    // ------------------------------------------------------------------
    // Priority select: rotate > left > right > down > pending gravity
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the if-chain, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_req      = 1'b0;
        w_user_req = 1'b0;
        w_sel_cmd  = CMD_NONE;
        if (w_rot) begin
            w_req      = 1'b1;
            w_user_req = 1'b1;
            w_sel_cmd  = '{op: ROT, auto: 1'b0};
        end else if (w_left) begin
            w_req      = 1'b1;
            w_user_req = 1'b1;
            w_sel_cmd  = '{op: LEFT, auto: 1'b0};
        end else if (w_right) begin
            w_req      = 1'b1;
            w_user_req = 1'b1;
            w_sel_cmd  = '{op: RIGHT, auto: 1'b0};
        end else if (w_down) begin
            w_req      = 1'b1;
            w_user_req = 1'b1;
            w_sel_cmd  = '{op: DOWN, auto: 1'b0};
        end else if (r_grav_pending) begin
            // Gravity may enqueue even while paused; only the timer freezes.
            w_req      = 1'b1;
            w_sel_cmd  = '{op: DOWN, auto: 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Handshake and queue write decision
    // ------------------------------------------------------------------
    assign cmd_valid = ~w_empty & ~pause;
    assign w_pop     = cmd_valid & cmd_ready;

    // A full queue still takes a write when the head leaves in the same cycle.
    assign w_space   = ~w_full | w_pop;
    assign w_push    = w_req & w_space;

    // A user command that cannot be written is lost; a gravity request that
    // cannot be written simply stays pending, so it never counts here.
    assign w_drop    = w_multi | (w_user_req & ~w_space);

    assign w_grav_push        = w_push & ~w_user_req;
    assign w_manual_down_push = w_push &  w_user_req & (w_sel_cmd.op == DOWN);

    // ------------------------------------------------------------------
    // Gravity timer
    // ------------------------------------------------------------------
    assign w_tick = ~pause & (r_grav_cnt == GRAV_LAST);

    // Later assignments win: a fresh tick re-arms the request even in the
    // cycle an older one is written, but a manual drop restarts the period and
    // swallows any tick, so the player never gets a second drop for free.
    always_comb begin
        w_cnt_next     = r_grav_cnt;
        w_pending_next = r_grav_pending;
        if (!pause) begin
            w_cnt_next = w_tick ? '0 : r_grav_cnt + 1'b1;
        end
        if (w_grav_push) begin
            w_pending_next = 1'b0;
        end
        if (w_tick) begin
            w_pending_next = 1'b1;
        end
        if (w_manual_down_push) begin
            w_cnt_next     = '0;
            w_pending_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grav_cnt     <= '0;
            r_grav_pending <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_grav_cnt     <= w_cnt_next;
            r_grav_pending <= w_pending_next;
            r_overflow     <= r_overflow | w_drop;
        end
    end

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    move_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_sel_cmd),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // The head is shown straight from storage; an empty queue reads as the
    // neutral command so the outputs are defined right after reset.
    assign cmd_op   = w_empty ? CMD_NONE.op   : w_head.op;
    assign cmd_auto = w_empty ? CMD_NONE.auto : w_head.auto;
    assign overflow = r_overflow;
    assign level    = w_level;

endmodule : move_sequencer
